// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_bridge
// Description : AHB-Lite slave to AMBA2 APB bridge; one SETUP+ENABLE access
//               per AHB NONSEQ/SEQ transfer, with wait states on HREADYout.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_bridge #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_SLAVES  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    REGION_LOG2 = 26
) (
  input  logic                  clock,
  input  logic                  HRESET,
  input  logic                  HSELAPBif,
  input  logic                  HREADYin,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYout,
  output logic [1:0]            HRESP,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int c_idx_w = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // One extra bit so the span of the full map never overflows the compare.
  localparam logic [ADDR_WIDTH:0] c_span = (ADDR_WIDTH+1)'(NUM_SLAVES) << REGION_LOG2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WWAIT  = 2'd1,
    S_SETUP  = 2'd2,
    S_ENABLE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_hready;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [c_idx_w-1:0]      r_idx;

  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_in_map;
  logic                    w_valid;
  logic [c_idx_w-1:0]      w_idx;
  logic                    w_unused;

  function automatic logic [NUM_SLAVES-1:0] f_onehot(input logic [c_idx_w-1:0] idx);
    return NUM_SLAVES'(1) << idx;
  endfunction

  assign w_offset = HADDR - BASE_ADDR;
  assign w_in_map = (HADDR >= BASE_ADDR) && ({1'b0, w_offset} < c_span);
  assign w_valid  = HSELAPBif & HREADYin & HTRANS[1] & w_in_map;
  assign w_idx    = c_idx_w'(w_offset >> REGION_LOG2);

  // Transfer size and burst type carry no meaning on APB; every access is a word.
  assign w_unused = ^{HSIZE, HBURST, HTRANS[0]};

  always_ff @(posedge clock or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_hready  <= 1'b1;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ENABLE: begin
          if (w_valid) begin
            r_paddr   <= HADDR;
            r_pwrite  <= HWRITE;
            r_idx     <= w_idx;
            r_penable <= 1'b0;
            r_hready  <= 1'b0;
            if (HWRITE) begin
              r_state <= S_WWAIT;
              r_psel  <= '0;
            end else begin
              r_state <= S_SETUP;
              r_psel  <= f_onehot(w_idx);
            end
          end else begin
            r_state   <= S_IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_hready  <= 1'b1;
          end
        end
        S_WWAIT: begin
          // Write data is only valid in the AHB data phase, one cycle after the address.
          r_pwdata  <= HWDATA;
          r_state   <= S_SETUP;
          r_psel    <= f_onehot(r_idx);
          r_penable <= 1'b0;
          r_hready  <= 1'b0;
        end
        S_SETUP: begin
          r_state   <= S_ENABLE;
          r_penable <= 1'b1;
          r_hready  <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_hready  <= 1'b1;
        end
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign HREADYout = r_hready;
  assign HRESP     = 2'b00;
  assign HRDATA    = ((r_state == S_ENABLE) && !r_pwrite) ? PRDATA : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb2apb_bridge
// Description : Directed self-checking bench for ahb2apb_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge;

  logic        clock = 1'b0;
  logic        HRESET;
  logic        HSELAPBif;
  logic        HREADYin;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYout;
  logic [1:0]  HRESP;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ahb2apb_bridge dut (
    .clock     (clock),
    .HRESET    (HRESET),
    .HSELAPBif (HSELAPBif),
    .HREADYin  (HREADYin),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYout (HREADYout),
    .HRESP     (HRESP),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then settle before checking.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic addr_phase(input logic sel, input logic [1:0] trans,
                            input logic write, input logic [31:0] addr);
    HSELAPBif = sel;
    HTRANS    = trans;
    HWRITE    = write;
    HADDR     = addr;
  endtask

  task automatic bus_idle();
    addr_phase(1'b0, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic chk_apb(input string tag, input logic [3:0] psel, input logic pen,
                         input logic hrdy);
    chk({tag, "_psel"}, {28'h0, PSEL}, {28'h0, psel});
    chk({tag, "_penable"}, {31'h0, PENABLE}, {31'h0, pen});
    chk({tag, "_hready"}, {31'h0, HREADYout}, {31'h0, hrdy});
  endtask

  logic [31:0] ign_addr [5];
  logic [1:0]  ign_trans[5];
  logic        ign_sel  [5];

  initial begin
    HRESET   = 1'b1;
    HREADYin = 1'b1;
    HSIZE    = 3'b010;
    HBURST   = 3'b000;
    HWDATA   = 32'h0;
    PRDATA   = 32'h0;
    bus_idle();

    // Reset state
    next_cycle();
    next_cycle();
    chk_apb("rst", 4'b0000, 1'b0, 1'b1);
    chk("rst_hresp", {30'h0, HRESP}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
    HRESET = 1'b0;
    next_cycle();

    // Single write: T0 address, T1 WWAIT, T2 SETUP, T3 ENABLE
    addr_phase(1'b1, 2'b10, 1'b1, 32'h8000_0010);
    #1 chk("wr_t0_hready", {31'h0, HREADYout}, 32'h1);
    next_cycle();
    bus_idle();
    HWDATA = 32'hDEAD_BEEF;
    #1 chk_apb("wr_t1", 4'b0000, 1'b0, 1'b0);
    next_cycle();
    HWDATA = 32'h0;
    #1 chk_apb("wr_t2", 4'b0001, 1'b0, 1'b0);
    chk("wr_t2_paddr", PADDR, 32'h8000_0010);
    chk("wr_t2_pwrite", {31'h0, PWRITE}, 32'h1);
    chk("wr_t2_pwdata", PWDATA, 32'hDEAD_BEEF);
    next_cycle();
    #1 chk_apb("wr_t3", 4'b0001, 1'b1, 1'b1);
    chk("wr_t3_pwdata", PWDATA, 32'hDEAD_BEEF);
    next_cycle();
    #1 chk_apb("wr_t4", 4'b0000, 1'b0, 1'b1);
    chk("wr_t4_paddr_hold", PADDR, 32'h8000_0010);
    chk("wr_t4_pwdata_hold", PWDATA, 32'hDEAD_BEEF);

    // Single read: T1 SETUP, T2 ENABLE with HRDATA = PRDATA
    addr_phase(1'b1, 2'b10, 1'b0, 32'h8400_0004);
    next_cycle();
    bus_idle();
    PRDATA = 32'h1234_5678;
    #1 chk_apb("rd_t1", 4'b0010, 1'b0, 1'b0);
    chk("rd_t1_hrdata", HRDATA, 32'h0);
    chk("rd_t1_pwrite", {31'h0, PWRITE}, 32'h0);
    chk("rd_t1_paddr", PADDR, 32'h8400_0004);
    next_cycle();
    #1 chk_apb("rd_t2", 4'b0010, 1'b1, 1'b1);
    chk("rd_t2_hrdata", HRDATA, 32'h1234_5678);
    next_cycle();
    #1 chk_apb("rd_t3", 4'b0000, 1'b0, 1'b1);
    chk("rd_t3_hrdata", HRDATA, 32'h0);

    // Back-to-back: read 8800_0000, write 8C00_0000 presented in read ENABLE
    addr_phase(1'b1, 2'b10, 1'b0, 32'h8800_0000);
    next_cycle();
    bus_idle();
    PRDATA = 32'hCAFE_F00D;
    #1 chk_apb("b2b_rd_setup", 4'b0100, 1'b0, 1'b0);
    next_cycle();
    addr_phase(1'b1, 2'b10, 1'b1, 32'h8C00_0000);
    #1 chk_apb("b2b_rd_enable", 4'b0100, 1'b1, 1'b1);
    chk("b2b_rd_hrdata", HRDATA, 32'hCAFE_F00D);
    chk("b2b_rd_hresp", {30'h0, HRESP}, 32'h0);
    next_cycle();
    bus_idle();
    HWDATA = 32'hA5A5_5A5A;
    #1 chk_apb("b2b_wwait", 4'b0000, 1'b0, 1'b0);
    chk("b2b_wwait_hresp", {30'h0, HRESP}, 32'h0);
    next_cycle();
    HWDATA = 32'h0;
    #1 chk_apb("b2b_wr_setup", 4'b1000, 1'b0, 1'b0);
    chk("b2b_wr_paddr", PADDR, 32'h8C00_0000);
    chk("b2b_wr_pwdata", PWDATA, 32'hA5A5_5A5A);
    chk("b2b_wr_pwrite", {31'h0, PWRITE}, 32'h1);
    next_cycle();
    #1 chk_apb("b2b_wr_enable", 4'b1000, 1'b1, 1'b1);
    chk("b2b_wr_hrdata", HRDATA, 32'h0);
    chk("b2b_wr_hresp", {30'h0, HRESP}, 32'h0);
    next_cycle();

    // Ignored transfers: BUSY, IDLE, deselected, above map, below map
    ign_sel[0] = 1'b1; ign_trans[0] = 2'b01; ign_addr[0] = 32'h8000_0000;
    ign_sel[1] = 1'b1; ign_trans[1] = 2'b00; ign_addr[1] = 32'h8000_0000;
    ign_sel[2] = 1'b0; ign_trans[2] = 2'b10; ign_addr[2] = 32'h8000_0000;
    ign_sel[3] = 1'b1; ign_trans[3] = 2'b10; ign_addr[3] = 32'h9000_0000;
    ign_sel[4] = 1'b1; ign_trans[4] = 2'b11; ign_addr[4] = 32'h7FFF_FFFC;
    for (int i = 0; i < 5; i++) begin
      addr_phase(ign_sel[i], ign_trans[i], 1'b0, ign_addr[i]);
      next_cycle();
      #1 chk_apb($sformatf("ign%0d", i), 4'b0000, 1'b0, 1'b1);
    end
    bus_idle();

    // HREADYin low: NONSEQ not captured
    HREADYin = 1'b0;
    addr_phase(1'b1, 2'b10, 1'b0, 32'h8000_0000);
    next_cycle();
    #1 chk_apb("hrdyin0", 4'b0000, 1'b0, 1'b1);
    HREADYin = 1'b1;
    bus_idle();
    next_cycle();
    #1 chk_apb("hrdyin0_after", 4'b0000, 1'b0, 1'b1);

    // Top of map via SEQ selects the last slave
    addr_phase(1'b1, 2'b11, 1'b0, 32'h8FFF_FFFC);
    next_cycle();
    bus_idle();
    #1 chk_apb("top_setup", 4'b1000, 1'b0, 1'b0);
    next_cycle();
    next_cycle();

    // Reset asserted mid-ENABLE clears outputs immediately
    addr_phase(1'b1, 2'b10, 1'b0, 32'h8000_0000);
    next_cycle();
    bus_idle();
    next_cycle();
    #1 chk_apb("pre_rst_enable", 4'b0001, 1'b1, 1'b1);
    HRESET = 1'b1;
    #1 chk_apb("async_rst", 4'b0000, 1'b0, 1'b1);
    chk("async_rst_hrdata", HRDATA, 32'h0);
    chk("async_rst_paddr", PADDR, 32'h0);
    next_cycle();
    HRESET = 1'b0;
    next_cycle();
    #1 chk_apb("post_rst", 4'b0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
